fco_frame_tx: RTL and testbench

- Transmit-side frame generator for the DCO domain: emits a continuous word stream plus a 1-cycle FCO pulse that marks every frame boundary.
- Drives the input of align_monitor_fco in loopback and serves as the ADC-side emulator in system benches.
- Sends a training preamble after enable, then streams upstream payload words.
- Supports on-demand single-word slip injection to exercise the receiver's re-lock path.

---
 rtl/fco_frame_tx.sv | 145 ++++++++++++++
 tb/tb_fco_frame_tx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fco_frame_tx.sv
// Transmit-side frame generator: continuous word stream with a one-cycle FCO pulse per frame,
// a training preamble after enable, payload streaming, and single-word slip injection.
module fco_frame_tx #(
  parameter int          FRAME_PERIOD  = 16,
  parameter int          DATA_W        = 16,
  parameter int          TRAIN_FRAMES  = 4,
  parameter logic [15:0] TRAIN_PATTERN = 16'hA5C3
) (
  input  logic              dco_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              slip_req,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              fco_out,
  output logic              training,
  output logic              underflow,
  output logic [15:0]       frame_cnt
);

  localparam int IDX_W = $clog2(FRAME_PERIOD + 1);
  localparam int TC_W  = (TRAIN_FRAMES < 2) ? 1 : $clog2(TRAIN_FRAMES);
  localparam logic [IDX_W-1:0]  LAST_N  = IDX_W'(FRAME_PERIOD - 1);
  localparam logic [IDX_W-1:0]  LAST_S  = IDX_W'(FRAME_PERIOD);
  localparam logic [TC_W-1:0]   TC_LAST = TC_W'(TRAIN_FRAMES - 1);
  localparam logic [DATA_W-1:0] PAT     = DATA_W'(TRAIN_PATTERN);

  typedef enum logic [1:0] {IDLE, TRAIN, RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [TC_W-1:0]   train_cnt, train_cnt_nxt;
  logic              slip_pending, slip_pending_nxt;
  logic              slipped, slipped_nxt;
  logic              insert_cycle, last_word;
  logic [DATA_W-1:0] word_nxt;
  logic              valid_nxt, fco_nxt, training_nxt, underflow_nxt;
  logic [15:0]       frame_cnt_nxt;

  always_ff @(posedge dco_clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      train_cnt    <= '0;
      slip_pending <= 1'b0;
      slipped      <= 1'b0;
      word_out     <= '0;
      word_valid   <= 1'b0;
      fco_out      <= 1'b0;
      training     <= 1'b0;
      underflow    <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      train_cnt    <= train_cnt_nxt;
      slip_pending <= slip_pending_nxt;
      slipped      <= slipped_nxt;
      word_out     <= word_nxt;
      word_valid   <= valid_nxt;
      fco_out      <= fco_nxt;
      training     <= training_nxt;
      underflow    <= underflow_nxt;
      frame_cnt    <= frame_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    train_cnt_nxt    = train_cnt;
    slip_pending_nxt = slip_pending;
    slipped_nxt      = slipped;
    word_nxt         = '0;
    valid_nxt        = 1'b0;
    fco_nxt          = 1'b0;
    training_nxt     = 1'b0;
    underflow_nxt    = underflow;
    frame_cnt_nxt    = frame_cnt;

    // A slipped frame carries a filler at FRAME_PERIOD-1 and ends one word later.
    insert_cycle = (state != IDLE) && slipped && (idx == LAST_N);
    last_word    = (idx == (slipped ? LAST_S : LAST_N));
    data_ready   = (state == RUN) && !insert_cycle;

    if (!enable) begin
      state_nxt        = IDLE;
      idx_nxt          = '0;
      train_cnt_nxt    = '0;
      slip_pending_nxt = 1'b0;
      slipped_nxt      = 1'b0;
      frame_cnt_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt        = TRAIN;
          idx_nxt          = '0;
          train_cnt_nxt    = '0;
          slip_pending_nxt = 1'b0;
          slipped_nxt      = 1'b0;
          underflow_nxt    = 1'b0;
          frame_cnt_nxt    = '0;
        end
        default: begin
          valid_nxt    = 1'b1;
          fco_nxt      = last_word;
          training_nxt = (state == TRAIN);
          if (state == TRAIN) begin
            word_nxt = PAT;
          end else if (insert_cycle) begin
            word_nxt = '0;
          end else if (data_valid) begin
            word_nxt = data_in;
          end else begin
            word_nxt      = '0;
            underflow_nxt = 1'b1;
          end

          if (last_word) begin
            idx_nxt          = '0;
            frame_cnt_nxt    = frame_cnt + 16'd1;
            slipped_nxt      = slip_pending;
            // A request landing on the boundary edge targets the frame after the one starting now.
            slip_pending_nxt = slip_req;
            if (state == TRAIN) begin
              if (train_cnt == TC_LAST) begin
                state_nxt     = RUN;
                train_cnt_nxt = '0;
              end else begin
                train_cnt_nxt = train_cnt + 1'b1;
              end
            end
          end else begin
            idx_nxt          = idx + 1'b1;
            slip_pending_nxt = slip_pending | slip_req;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fco_frame_tx.sv
// Directed + randomized bench for fco_frame_tx against a frame-level reference model.
module tb_fco_frame_tx;

  localparam int          FP  = 16;
  localparam int          TF  = 4;
  localparam logic [15:0] PAT = 16'hA5C3;

  logic        dco_clk = 1'b0;
  logic        rst_n, enable, data_valid, slip_req;
  logic [15:0] data_in;
  logic        data_ready, word_valid, fco_out, training, underflow;
  logic [15:0] word_out, frame_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: position in frame, frame length, frames sent since start.
  bit          m_run = 0;
  int          m_pos = 0;
  int          m_len = FP;
  int          m_frames = 0;
  bit          m_pend = 0;
  bit          m_uf = 0;
  logic [15:0] e_word, e_fcnt;
  logic        e_valid, e_fco, e_train, e_uf;

  logic [15:0] pay;
  bit          hs;
  int          guard;

  always #5 dco_clk = ~dco_clk;

  fco_frame_tx #(.FRAME_PERIOD(FP), .DATA_W(16), .TRAIN_FRAMES(TF), .TRAIN_PATTERN(PAT)) dut (
    .dco_clk(dco_clk), .rst_n(rst_n), .enable(enable), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .slip_req(slip_req),
    .word_out(word_out), .word_valid(word_valid), .fco_out(fco_out),
    .training(training), .underflow(underflow), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit filler;
    bit train;
    e_word = '0; e_valid = 0; e_fco = 0; e_train = 0;
    if (!rst_n) begin
      m_run = 0; m_uf = 0; m_frames = 0; m_pend = 0;
    end else if (!enable) begin
      m_run = 0; m_frames = 0; m_pend = 0;
    end else if (!m_run) begin
      m_run = 1; m_pos = 0; m_len = FP; m_frames = 0; m_pend = 0; m_uf = 0;
    end else begin
      train   = (m_frames < TF);
      filler  = (m_len == FP + 1) && (m_pos == FP - 1);
      e_valid = 1;
      e_train = train;
      e_fco   = (m_pos == m_len - 1);
      if (train) e_word = PAT;
      else if (filler) e_word = '0;
      else if (data_valid) e_word = data_in;
      else begin e_word = '0; m_uf = 1; end
      if (e_fco) begin
        m_frames++;
        m_pos  = 0;
        m_len  = m_pend ? FP + 1 : FP;
        m_pend = slip_req;
      end else begin
        m_pos++;
        m_pend = m_pend | slip_req;
      end
    end
    e_uf   = m_uf;
    e_fcnt = 16'(m_frames);
  endtask

  // Inputs are already driven; check combinational ready, step model, clock, check registers.
  task automatic tick();
    bit exp_ready;
    exp_ready = m_run && (m_frames >= TF) && !((m_len == FP + 1) && (m_pos == FP - 1));
    #1;
    chk("data_ready", {31'd0, data_ready}, {31'd0, exp_ready});
    model_step();
    @(posedge dco_clk);
    #1;
    chk("word_out",   {16'd0, word_out},   {16'd0, e_word});
    chk("word_valid", {31'd0, word_valid}, {31'd0, e_valid});
    chk("fco_out",    {31'd0, fco_out},    {31'd0, e_fco});
    chk("training",   {31'd0, training},   {31'd0, e_train});
    chk("underflow",  {31'd0, underflow},  {31'd0, e_uf});
    chk("frame_cnt",  {16'd0, frame_cnt},  {16'd0, e_fcnt});
    @(negedge dco_clk);
  endtask

  // Stream payload with an incrementing counter that only advances on a handshake.
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      data_in = pay;
      hs = data_ready && data_valid;
      tick();
      if (hs) pay++;
    end
  endtask

  initial begin
    rst_n = 0; enable = 0; data_valid = 0; slip_req = 0; data_in = '0; pay = 16'h1000;
    @(negedge dco_clk);
    tick();
    tick();
    chk("reset_word_valid", {31'd0, word_valid}, 32'd0);
    chk("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);

    // Training preamble then payload.
    rst_n = 1; enable = 1; data_valid = 1;
    stream(1);
    chk("latency_no_word_yet", {31'd0, word_valid}, 32'd0);
    stream(1);
    chk("first_word_valid", {31'd0, word_valid}, 32'd1);
    stream(63);
    chk("train_end_fco", {31'd0, fco_out}, 32'd1);
    chk("train_end_frame_cnt", {16'd0, frame_cnt}, 32'd4);
    stream(1);
    chk("first_payload", {16'd0, word_out}, 32'h1000);
    chk("first_payload_training", {31'd0, training}, 32'd0);
    stream(40);

    // Slip request mid-frame, plus a duplicate that must be ignored.
    guard = 0;
    while (m_pos != 5 && guard < 40) begin stream(1); guard++; end
    chk("slip_align_bound", guard < 40, 32'd1);
    slip_req = 1; stream(1);
    slip_req = 0; stream(2);
    slip_req = 1; stream(1);
    slip_req = 0; stream(60);

    // Three-cycle underflow.
    data_valid = 0; stream(3);
    data_valid = 1; stream(5);
    chk("underflow_sticky", {31'd0, underflow}, 32'd1);
    stream(30);

    // Randomized traffic with occasional mid-frame slips.
    for (int i = 0; i < 500; i++) begin
      data_valid = ($urandom_range(0, 9) != 0);
      data_in    = 16'($urandom);
      slip_req   = (m_pos >= 2) && (m_pos <= FP - 3) && ($urandom_range(0, 19) == 0);
      tick();
    end
    slip_req = 0; data_valid = 1;

    // Enable dropped at word index 7, restored 5 cycles later.
    guard = 0;
    while (!(m_run && m_pos == 7) && guard < 40) begin stream(1); guard++; end
    chk("disable_align_bound", guard < 40, 32'd1);
    enable = 0;
    stream(1);
    chk("disable_word_valid", {31'd0, word_valid}, 32'd0);
    chk("disable_fco", {31'd0, fco_out}, 32'd0);
    stream(4);
    enable = 1;
    stream(2);
    chk("restart_training", {31'd0, training}, 32'd1);
    chk("restart_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    chk("restart_underflow", {31'd0, underflow}, 32'd0);
    stream(100);

    // One-cycle reset mid-RUN with enable held high.
    rst_n = 0; stream(1);
    chk("midrun_reset_valid", {31'd0, word_valid}, 32'd0);
    rst_n = 1; stream(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
